uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, giving clk cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rd_ack  input  1  consumer acknowledge; clears dout_valid.
REQ-006 SHALL have port dout  output  8  last correctly framed byte received.
REQ-007 SHALL have port dout_valid  output  1  level, high while dout holds an unacknowledged byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port overrun  output  1  sticky flag: a byte was overwritten before acknowledge.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx_data through a 2-flop synchronizer (both flops reset to 1); all FSM decisions use the synchronized bit rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA and STOP, plus a bit-period counter and a 3-bit bit index.
REQ-013 In IDLE, when rx_s=0, the FSM SHALL go to START with the counter cleared.
REQ-014 In START, at counter=(CLKS_PER_BIT-1)/2 (integer division), the FSM SHALL sample rx_s: 0 -> DATA, counter cleared, index 0; 1 -> IDLE (false start, no output change).
REQ-015 In DATA, at counter=CLKS_PER_BIT-1, the FSM SHALL shift rx_s into the shift register LSB-first and clear the counter; after index 7 it SHALL go to STOP, otherwise increment the index.
REQ-016 In STOP, at counter=CLKS_PER_BIT-1, the FSM SHALL sample rx_s and return to IDLE on the same edge.
- Sample 1: load dout from the shift register and set dout_valid on the next cycle.
- Sample 0: pulse frame_err for exactly one cycle; leave dout and dout_valid unchanged.
REQ-017 The counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap within a bit period.
REQ-018 rd_ack while dout_valid=1 SHALL clear dout_valid on the next cycle; rd_ack while dout_valid=0 SHALL be ignored.
REQ-019 Good byte completes while dout_valid=1 and rd_ack=0: dout SHALL be overwritten, dout_valid SHALL stay 1, overrun SHALL set.
REQ-020 Good byte completes in the same cycle as rd_ack: dout SHALL take the new byte, dout_valid SHALL stay 1, overrun SHALL not set.
REQ-021 overrun SHALL clear on rd_ack; if a set and a clear occur in the same cycle, set SHALL win.
REQ-022 busy SHALL be combinationally (state != IDLE).
REQ-023 Line-to-output latency SHALL be: dout_valid rises 2 + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles (+/-1) after the start-bit falling edge on rx_data.
REQ-024 Back-to-back frames with no idle time between stop bit and next start bit SHALL be received without loss.

Reset
REQ-025 While rstn=0 the block SHALL hold: state IDLE, counter 0, index 0, shift register 0x00, dout 0x00, dout_valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; after release, reception SHALL resume only on a new falling edge of rx_data.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state encoding and the default CLKS_PER_BIT (217); the existing transmitter SHALL reuse the same constant.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (async active-low reset, parameterized reset value).

Verification (sim with CLKS_PER_BIT=8 unless noted)
REQ-029 Send 0xA5 as a clean 8N1 frame -> dout=0xA5, dout_valid=1, frame_err never pulses, busy low afterwards.
REQ-030 Send a 3-cycle low glitch on an idle line -> FSM returns to IDLE from START; dout_valid stays 0; no frame_err.
REQ-031 Send 0x3C with the stop bit forced 0 -> exactly one frame_err pulse; dout and dout_valid unchanged.
REQ-032 Send 0x11 then 0x22 back-to-back without rd_ack -> dout=0x22, overrun=1; then rd_ack -> dout_valid=0 and overrun=0.
REQ-033 Pulse rd_ack on the same cycle 0x7E completes (previous byte pending) -> dout=0x7E, dout_valid=1, overrun=0.
REQ-034 Loopback through the existing transmitter at CLKS_PER_BIT=217, bytes 0x00, 0xFF, 0x55, with rstn pulsed mid-way through the second byte -> bytes 1 and 3 received correctly, byte 2 dropped, no spurious frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing default, receiver FSM encoding and
// counter sizing helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 217;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned IDX_W            = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_e;

  // Bits needed to hold cpb-1 without wrapping inside one bit period.
  function automatic int unsigned cnt_width(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with a single-entry output holding
// register, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_data,
  input  logic       rd_ack,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned    CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_e       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 stop_good_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx_data),
    .q    (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, bit timing and output-holding logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    ovr_d       = ovr_q;
    stop_good_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            stop_good_c = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Consumer handshake; a completing byte takes priority over the ack.
    if (valid_q && rd_ack) begin
      valid_d = 1'b0;
    end
    if (rd_ack) begin
      ovr_d = 1'b0;
    end
    if (stop_good_c) begin
      dout_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rd_ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx: fast-timing instance for protocol
// corners, default-timing instance for serial loopback with a mid-frame reset.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB   = 8;
  localparam int unsigned CPB_L = CLKS_PER_BIT_DEF;

  typedef enum int {EV_GOOD, EV_FERR, EV_FALSE} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] dout;
    logic       valid;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_a = 1'b1;
  logic ack_a = 1'b0;
  logic [7:0] dout_a;
  logic valid_a, ferr_a, ovr_a, busy_a;

  logic rstn_b = 1'b0;
  logic rx_b = 1'b1;
  logic ack_b = 1'b0;
  logic [7:0] dout_b;
  logic valid_b, ferr_b, ovr_b, busy_b;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q_a[$];
  logic [7:0] q_b[$];
  int ferr_a_cycles = 0;
  int ferr_b_cycles = 0;
  int frames_b = 0;
  int ev_idx = 0;
  logic busy_prev_a = 1'b0;
  logic valid_prev_b = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rstn(rstn), .rx_data(rx_a), .rd_ack(ack_a),
    .dout(dout_a), .dout_valid(valid_a), .frame_err(ferr_a),
    .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_L)) dut_b (
    .clk(clk), .rstn(rstn_b), .rx_data(rx_b), .rd_ack(ack_b),
    .dout(dout_b), .dout_valid(valid_b), .frame_err(ferr_b),
    .overrun(ovr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input ev_e k, input logic [7:0] d, input logic v, input logic o);
    exp_t e;
    e.kind = k; e.dout = d; e.valid = v; e.ovr = o;
    return e;
  endfunction

  // Every return to IDLE on instance A is one scoreboard event.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ferr_a) ferr_a_cycles++;
    if (rstn && busy_prev_a && !busy_a) begin
      if (q_a.size() == 0) begin
        check($sformatf("ev%0d_unexpected", ev_idx), 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check($sformatf("ev%0d_dout", ev_idx), 32'(dout_a), 32'(e.dout));
        check($sformatf("ev%0d_valid", ev_idx), 32'(valid_a), 32'(e.valid));
        check($sformatf("ev%0d_overrun", ev_idx), 32'(ovr_a), 32'(e.ovr));
        check($sformatf("ev%0d_frame_err", ev_idx), 32'(ferr_a), 32'(e.kind == EV_FERR));
      end
      ev_idx++;
    end
    busy_prev_a = busy_a;
  end

  // Instance B: each rising dout_valid delivers one byte.
  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (ferr_b) ferr_b_cycles++;
    if (rstn_b && valid_b && !valid_prev_b) begin
      frames_b++;
      if (q_b.size() == 0) begin
        check("loop_unexpected_byte", 32'(dout_b), 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        check($sformatf("loop_byte%0d", frames_b), 32'(dout_b), 32'(e));
      end
    end
    valid_prev_b = valid_b;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame on line A; optionally ack in the cycle the stop bit is sampled.
  task automatic send_a(input logic [7:0] d, input logic stop, input logic ack_on_done);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_a = fr[i];
      if (i == 9 && ack_on_done) begin
        step(int'(CPB) - 2);
        ack_a = 1'b1;
        step(1);
        ack_a = 1'b0;
        step(1);
      end else begin
        step(int'(CPB));
      end
    end
  endtask

  task automatic send_b(input logic [7:0] d, input int abort_bit);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_b = fr[i];
      if (i == abort_bit) begin
        step(10);
        rstn_b = 1'b0;
        step(5);
        rstn_b = 1'b1;
        step(int'(CPB_L) - 15);
      end else begin
        step(int'(CPB_L));
      end
    end
  endtask

  task automatic pulse_ack_a();
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0;
  endtask

  task automatic drain_a(input string tag, input int max_cycles);
    int n = 0;
    while (q_a.size() != 0 && n < max_cycles) begin
      step(1);
      n++;
    end
    check(tag, 32'(q_a.size()), 32'd0);
  endtask

  task automatic drain_b(input string tag, input int max_cycles);
    int n = 0;
    while (q_b.size() != 0 && n < max_cycles) begin
      step(1);
      n++;
    end
    check(tag, 32'(q_b.size()), 32'd0);
  endtask

  initial begin
    step(5);
    check("rst_dout", 32'(dout_a), 32'h00);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_frame_err", 32'(ferr_a), 32'd0);
    check("rst_overrun", 32'(ovr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_b_valid", 32'(valid_b), 32'd0);
    rstn = 1'b1;
    rstn_b = 1'b1;
    step(5);

    q_a.push_back(mk(EV_GOOD, 8'hA5, 1'b1, 1'b0));
    send_a(8'hA5, 1'b1, 1'b0);
    drain_a("a5_drain", 200);
    check("a5_busy_after", 32'(busy_a), 32'd0);
    check("a5_no_frame_err", 32'(ferr_a_cycles), 32'd0);
    pulse_ack_a();
    check("a5_ack_valid", 32'(valid_a), 32'd0);

    q_a.push_back(mk(EV_FALSE, 8'hA5, 1'b0, 1'b0));
    rx_a = 1'b0;
    step(3);
    rx_a = 1'b1;
    step(20);
    drain_a("glitch_drain", 100);
    check("glitch_valid", 32'(valid_a), 32'd0);
    check("glitch_no_frame_err", 32'(ferr_a_cycles), 32'd0);

    // The line is still low when the FSM leaves STOP, so a false start follows the error.
    q_a.push_back(mk(EV_FERR, 8'hA5, 1'b0, 1'b0));
    q_a.push_back(mk(EV_FALSE, 8'hA5, 1'b0, 1'b0));
    send_a(8'h3C, 1'b0, 1'b0);
    rx_a = 1'b1;
    step(2 * int'(CPB));
    drain_a("ferr_drain", 200);
    check("ferr_pulse_cycles", 32'(ferr_a_cycles), 32'd1);
    check("ferr_dout_kept", 32'(dout_a), 32'hA5);
    check("ferr_valid_kept", 32'(valid_a), 32'd0);

    q_a.push_back(mk(EV_GOOD, 8'h11, 1'b1, 1'b0));
    q_a.push_back(mk(EV_GOOD, 8'h22, 1'b1, 1'b1));
    send_a(8'h11, 1'b1, 1'b0);
    send_a(8'h22, 1'b1, 1'b0);
    drain_a("b2b_drain", 200);
    pulse_ack_a();
    check("ovr_ack_valid", 32'(valid_a), 32'd0);
    check("ovr_ack_overrun", 32'(ovr_a), 32'd0);

    q_a.push_back(mk(EV_GOOD, 8'h44, 1'b1, 1'b0));
    q_a.push_back(mk(EV_GOOD, 8'h7E, 1'b1, 1'b0));
    send_a(8'h44, 1'b1, 1'b0);
    send_a(8'h7E, 1'b1, 1'b1);
    drain_a("same_cycle_drain", 200);
    check("same_cycle_dout", 32'(dout_a), 32'h7E);
    check("same_cycle_valid", 32'(valid_a), 32'd1);
    check("same_cycle_overrun", 32'(ovr_a), 32'd0);
    pulse_ack_a();

    q_b.push_back(8'h00);
    send_b(8'h00, -1);
    drain_b("loop_byte1_drain", 4 * int'(CPB_L));
    ack_b = 1'b1;
    step(1);
    ack_b = 1'b0;
    send_b(8'hFF, 4);
    check("loop_reset_busy", 32'(busy_b), 32'd0);
    check("loop_reset_valid", 32'(valid_b), 32'd0);
    q_b.push_back(8'h55);
    send_b(8'h55, -1);
    drain_b("loop_byte3_drain", 4 * int'(CPB_L));
    check("loop_frames", 32'(frames_b), 32'd2);
    check("loop_no_frame_err", 32'(ferr_b_cycles), 32'd0);
    check("loop_last_dout", 32'(dout_b), 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
